// File: rtl/zap_wb_arbiter.sv
// zap_wb_arbiter: two-master to one-slave Wishbone arbiter with registered
// round-robin grant. A grant is held for the whole CYC, so bursts stay intact.
// Optional stalled-slave timeout is enabled with `define ZAP_WB_ARB_TIMEOUT_EN.
module zap_wb_arbiter #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_m0_cyc,
   input  logic        i_m0_stb,
   input  logic        i_m0_we,
   input  logic [31:0] i_m0_adr,
   input  logic [31:0] i_m0_dat,
   input  logic [3:0]  i_m0_sel,
   input  logic [2:0]  i_m0_cti,
   output logic [31:0] o_m0_dat,
   output logic        o_m0_ack,
   input  logic        i_m1_cyc,
   input  logic        i_m1_stb,
   input  logic        i_m1_we,
   input  logic [31:0] i_m1_adr,
   input  logic [31:0] i_m1_dat,
   input  logic [3:0]  i_m1_sel,
   input  logic [2:0]  i_m1_cti,
   output logic [31:0] o_m1_dat,
   output logic        o_m1_ack,
   output logic        o_s_cyc,
   output logic        o_s_stb,
   output logic        o_s_we,
   output logic [31:0] o_s_adr,
   output logic [31:0] o_s_dat,
   output logic [3:0]  o_s_sel,
   output logic [2:0]  o_s_cti,
   input  logic [31:0] i_s_dat,
   input  logic        i_s_ack,
   output logic [1:0]  o_gnt,
   output logic        o_timeout
);

   typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

   state_t state, state_nxt;
   logic   last, last_nxt;   // master granted most recently
   logic   fire;             // synthetic ack this cycle

   // Next-state: decide only from IDLE, hold grant while the owner keeps CYC.
   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      case (state)
         IDLE: begin
            if (i_m0_cyc && i_m1_cyc) begin
               state_nxt = last ? GNT0 : GNT1;
               last_nxt  = ~last;
            end else if (i_m0_cyc) begin
               state_nxt = GNT0;
               last_nxt  = 1'b0;
            end else if (i_m1_cyc) begin
               state_nxt = GNT1;
               last_nxt  = 1'b1;
            end
         end
         GNT0:    if (!i_m0_cyc) state_nxt = IDLE;
         GNT1:    if (!i_m1_cyc) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Grant state and round-robin history; reset makes master 0 win the first tie.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state <= IDLE;
         last  <= 1'b1;
      end else begin
         state <= state_nxt;
         last  <= last_nxt;
      end
   end

   // Bus mux: slave sees only the granted master, only the granted master sees ack/data.
   always_comb begin
      o_s_cyc  = 1'b0;
      o_s_stb  = 1'b0;
      o_s_we   = 1'b0;
      o_s_adr  = 32'h0;
      o_s_dat  = 32'h0;
      o_s_sel  = 4'h0;
      o_s_cti  = 3'h0;
      o_m0_ack = 1'b0;
      o_m0_dat = 32'h0;
      o_m1_ack = 1'b0;
      o_m1_dat = 32'h0;
      o_gnt    = 2'b00;
      case (state)
         GNT0: begin
            o_gnt    = 2'b01;
            o_s_cyc  = i_m0_cyc;
            o_s_stb  = i_m0_stb & ~fire;
            o_s_we   = i_m0_we;
            o_s_adr  = i_m0_adr;
            o_s_dat  = i_m0_dat;
            o_s_sel  = i_m0_sel;
            o_s_cti  = i_m0_cti;
            o_m0_ack = i_s_ack | fire;
            o_m0_dat = fire ? 32'hDEAD_BEEF : i_s_dat;
         end
         GNT1: begin
            o_gnt    = 2'b10;
            o_s_cyc  = i_m1_cyc;
            o_s_stb  = i_m1_stb & ~fire;
            o_s_we   = i_m1_we;
            o_s_adr  = i_m1_adr;
            o_s_dat  = i_m1_dat;
            o_s_sel  = i_m1_sel;
            o_s_cti  = i_m1_cti;
            o_m1_ack = i_s_ack | fire;
            o_m1_dat = fire ? 32'hDEAD_BEEF : i_s_dat;
         end
         default: ;
      endcase
   end

`ifdef ZAP_WB_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

   logic [CW-1:0] stall_cnt;
   logic          timeout_q;

   assign fire      = (state != IDLE) && (stall_cnt == CW'(TIMEOUT_CYCLES));
   assign o_timeout = timeout_q | fire;

   // Count stalled strobes; any ack, a synthetic ack or losing the grant restarts it.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         stall_cnt <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (fire)
            timeout_q <= 1'b1;
         if (fire || i_s_ack || state_nxt == IDLE)
            stall_cnt <= '0;
         else if (o_s_stb)
            stall_cnt <= stall_cnt + 1'b1;
      end
   end
`else
   logic unused_timeout;

   assign fire           = 1'b0;
   assign o_timeout      = 1'b0;
   assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_zap_wb_arbiter.sv
// Bench for zap_wb_arbiter: directed scenarios with literal expectations, then
// randomized masters/slave checked every cycle against a behavioural model.
module tb_zap_wb_arbiter;
   localparam int TO = 8;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        m_cyc[2], m_stb[2], m_we[2];
   logic [31:0] m_adr[2], m_dat[2];
   logic [3:0]  m_sel[2];
   logic [2:0]  m_cti[2];
   logic [31:0] s_dat;
   logic        s_ack;

   logic [31:0] o_m0_dat, o_m1_dat, o_s_adr, o_s_dat;
   logic        o_m0_ack, o_m1_ack, o_s_cyc, o_s_stb, o_s_we, o_timeout;
   logic [3:0]  o_s_sel;
   logic [2:0]  o_s_cti;
   logic [1:0]  o_gnt;

   int checks = 0;
   int errors = 0;

   zap_wb_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_m0_cyc(m_cyc[0]), .i_m0_stb(m_stb[0]), .i_m0_we(m_we[0]), .i_m0_adr(m_adr[0]),
      .i_m0_dat(m_dat[0]), .i_m0_sel(m_sel[0]), .i_m0_cti(m_cti[0]),
      .o_m0_dat(o_m0_dat), .o_m0_ack(o_m0_ack),
      .i_m1_cyc(m_cyc[1]), .i_m1_stb(m_stb[1]), .i_m1_we(m_we[1]), .i_m1_adr(m_adr[1]),
      .i_m1_dat(m_dat[1]), .i_m1_sel(m_sel[1]), .i_m1_cti(m_cti[1]),
      .o_m1_dat(o_m1_dat), .o_m1_ack(o_m1_ack),
      .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_we(o_s_we), .o_s_adr(o_s_adr),
      .o_s_dat(o_s_dat), .o_s_sel(o_s_sel), .o_s_cti(o_s_cti),
      .i_s_dat(s_dat), .i_s_ack(s_ack),
      .o_gnt(o_gnt), .o_timeout(o_timeout)
   );

   always #5 i_clk = ~i_clk;

   // ---------------- behavioural model ----------------
   int owner = 0;   // 0 = nobody, 1 = master 0, 2 = master 1
   bit mlast = 1'b1;
   int stall = 0;
   bit sticky = 1'b0;

   function automatic bit m_fire();
`ifdef ZAP_WB_ARB_TIMEOUT_EN
      return (owner != 0) && (stall == TO);
`else
      return 1'b0;
`endif
   endfunction

   function automatic int next_owner();
      if (owner == 0) begin
         if (m_cyc[0] && m_cyc[1]) return mlast ? 1 : 2;
         if (m_cyc[0]) return 1;
         if (m_cyc[1]) return 2;
         return 0;
      end
      return m_cyc[owner-1] ? owner : 0;
   endfunction

   always @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         owner  <= 0;
         mlast  <= 1'b1;
         stall  <= 0;
         sticky <= 1'b0;
      end else begin
         owner <= next_owner();
         if (owner == 0 && next_owner() != 0) mlast <= (next_owner() == 2);
         if (next_owner() == 0 || m_fire() || s_ack) stall <= 0;
         else if (owner != 0 && m_stb[owner-1]) stall <= stall + 1;
         if (m_fire()) sticky <= 1'b1;
      end
   end

   function automatic logic [142:0] expv();
      logic [1:0]  g = 2'b00;
      logic        cy = 0, st = 0, we = 0, a0 = 0, a1 = 0, to = 0;
      logic [31:0] ad = 0, dt = 0, d0 = 0, d1 = 0;
      logic [3:0]  se = 0;
      logic [2:0]  ct = 0;
      bit          f = m_fire();
      if (owner != 0) begin
         int k = owner - 1;
         g  = (owner == 1) ? 2'b01 : 2'b10;
         cy = m_cyc[k]; st = m_stb[k] & ~f; we = m_we[k];
         ad = m_adr[k]; dt = m_dat[k]; se = m_sel[k]; ct = m_cti[k];
         if (k == 0) begin a0 = s_ack | f; d0 = f ? 32'hDEAD_BEEF : s_dat; end
         else        begin a1 = s_ack | f; d1 = f ? 32'hDEAD_BEEF : s_dat; end
      end
`ifdef ZAP_WB_ARB_TIMEOUT_EN
      to = sticky | f;
`endif
      return {g, cy, st, we, ad, dt, se, ct, a0, d0, a1, d1, to};
   endfunction

   wire [142:0] actv = {o_gnt, o_s_cyc, o_s_stb, o_s_we, o_s_adr, o_s_dat, o_s_sel,
                        o_s_cti, o_m0_ack, o_m0_dat, o_m1_ack, o_m1_dat, o_timeout};

   task automatic chk_vec(string name, logic [142:0] act, logic [142:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
      end
   endtask

   task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
      end
   endtask

   // Every cycle, away from the active edge, the DUT must match the model.
   always @(negedge i_clk) chk_vec("model", actv, expv());

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge i_clk);
   endtask

   task automatic drive_m(int m, bit cyc, bit we, logic [31:0] adr, logic [31:0] dat,
                          logic [3:0] sel, logic [2:0] cti);
      m_cyc[m] = cyc; m_stb[m] = cyc; m_we[m] = we;
      m_adr[m] = adr; m_dat[m] = dat; m_sel[m] = sel; m_cti[m] = cti;
   endtask

   bit          ak[2];
   int          left[2];
   logic [1:0]  gq[$];
   logic [1:0]  comp[$];
   int          n;
   int          exp_rr[8] = '{0, 1, 0, 2, 0, 1, 0, 2};

   initial begin
      #1_000_000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1);
   end

   initial begin
      i_reset = 1'b1;
      for (int m = 0; m < 2; m++) drive_m(m, 0, 0, 0, 0, 0, 0);
      s_ack = 0; s_dat = 0;

      // reset state
      at_neg();
      chk32("reset_gnt", 32'(o_gnt), 0);
      chk32("reset_ctl", 32'({o_s_cyc, o_s_stb, o_m0_ack, o_m1_ack, o_timeout}), 0);
      @(posedge i_clk); #3 i_reset = 1'b0;

      // single read from master 0
      step(); drive_m(0, 1, 0, 32'h7C8, 0, 4'hF, 3'b000);
      at_neg(); chk32("grant_latency", 32'(o_gnt), 0);
      step();
      at_neg(); chk32("single_gnt", 32'(o_gnt), 1);
      chk32("single_adr", o_s_adr, 32'h7C8);
      chk32("single_cyc", 32'(o_s_cyc), 1);
      step(); s_ack = 1; s_dat = 32'h1234_5678;
      at_neg(); chk32("single_ack", 32'(o_m0_ack), 1);
      chk32("single_dat", o_m0_dat, 32'h1234_5678);
      chk32("single_m1_ack", 32'(o_m1_ack), 0);
      step(); s_ack = 0; m_cyc[0] = 0; m_stb[0] = 0;
      step(); step();

      // reset mid-transfer with both masters active
      drive_m(0, 1, 1, 32'hA0, 32'h1111_1111, 4'hF, 3'b000);
      drive_m(1, 1, 1, 32'hB0, 32'h2222_2222, 4'hF, 3'b000);
      step(); step(); s_ack = 1; s_dat = 32'h5A5A_5A5A;
      at_neg(); chk32("pre_reset_gnt", 32'(o_gnt), 2);
      @(posedge i_clk); #3 i_reset = 1'b1; #1;
      chk32("reset_async_gnt", 32'(o_gnt), 0);
      chk32("reset_async_bus", o_s_adr | o_s_dat | o_m0_dat | o_m1_dat, 0);
      chk32("reset_async_ctl",
            32'({o_s_cyc, o_s_stb, o_s_we, o_s_sel, o_s_cti, o_m0_ack, o_m1_ack, o_timeout}), 0);
      @(posedge i_clk); #3 i_reset = 1'b0;

      // round-robin: both masters re-request right after each completed cycle
      for (int i = 0; i < 18; i++) begin
         at_neg();
         gq.push_back(o_gnt);
         ak[0] = o_m0_ack; ak[1] = o_m1_ack;
         step();
         for (int m = 0; m < 2; m++) begin
            if (m_cyc[m] && ak[m]) begin m_cyc[m] = 0; m_stb[m] = 0; end
            else if (!m_cyc[m])     begin m_cyc[m] = 1; m_stb[m] = 1; end
         end
      end
      foreach (gq[i]) if (comp.size() == 0 || comp[comp.size()-1] != gq[i]) comp.push_back(gq[i]);
      for (int k = 0; k < 8; k++)
         chk32($sformatf("rr_seq_%0d", k), (k < comp.size()) ? 32'(comp[k]) : 32'hFFFF_FFFF,
               32'(exp_rr[k]));
      drive_m(0, 0, 0, 0, 0, 0, 0); drive_m(1, 0, 0, 0, 0, 0, 0); s_ack = 0;
      step(); step(); step();

      // burst hold: 4-beat incrementing burst from master 1, master 0 arrives after beat 1
      drive_m(1, 1, 0, 32'h100, 0, 4'hF, 3'b010); s_ack = 1;
      for (int b = 0; b < 4; b++) begin
         step();
         m_adr[1] = 32'h100 + 32'(4 * b);
         m_cti[1] = (b == 3) ? 3'b111 : 3'b010;
         if (b == 1) drive_m(0, 1, 0, 32'h300, 0, 4'hF, 3'b000);
         at_neg();
         chk32($sformatf("burst_gnt_%0d", b), 32'(o_gnt), 2);
         chk32($sformatf("burst_ack_%0d", b), 32'({o_m1_ack, o_m0_ack}), 2);
         chk32($sformatf("burst_cti_%0d", b), 32'(o_s_cti), (b == 3) ? 7 : 2);
      end
      step(); m_cyc[1] = 0; m_stb[1] = 0; s_ack = 0;
      at_neg(); chk32("burst_drop_gnt", 32'(o_gnt), 2);
      step(); at_neg(); chk32("burst_idle_gnt", 32'(o_gnt), 0);
      step(); at_neg(); chk32("burst_next_gnt", 32'(o_gnt), 1);
      step(); s_ack = 1;
      step(); m_cyc[0] = 0; m_stb[0] = 0; s_ack = 0;
      step(); step();

      // write mux: master 1 writes while master 0 waits with different values
      drive_m(1, 1, 1, 32'h800, 32'hCAFE_F00D, 4'b0011, 3'b000);
      step(); drive_m(0, 1, 0, 32'h111, 32'h5555_5555, 4'b1100, 3'b001);
      at_neg();
      chk32("wr_gnt", 32'(o_gnt), 2);
      chk32("wr_dat", o_s_dat, 32'hCAFE_F00D);
      chk32("wr_adr", o_s_adr, 32'h800);
      chk32("wr_sel_we_cti", 32'({o_s_sel, o_s_we, o_s_cti}), 32'({4'b0011, 1'b1, 3'b000}));
      step(); s_ack = 1;
      step(); m_cyc[1] = 0; m_stb[1] = 0; s_ack = 0;

      // stalled slave on master 0
      n = 0;
      at_neg();
      while (o_gnt != 2'b01 && n < 10) begin step(); at_neg(); n++; end
      chk32("stall_gnt", 32'(o_gnt), 1);
      n = 0;
      while (!o_m0_ack && n < 40) begin step(); at_neg(); n++; end
`ifdef ZAP_WB_ARB_TIMEOUT_EN
      chk32("to_stall_cycles", n, TO);
      chk32("to_dat", o_m0_dat, 32'hDEAD_BEEF);
      chk32("to_stb", 32'(o_s_stb), 0);
      chk32("to_flag", 32'(o_timeout), 1);
      step(); at_neg();
      chk32("to_flag_sticky", 32'(o_timeout), 1);
      chk32("to_ack_single", 32'(o_m0_ack), 0);
`else
      chk32("stall_no_ack", n, 40);
      chk32("stall_no_timeout", 32'(o_timeout), 0);
`endif
      m_cyc[0] = 0; m_stb[0] = 0;
      @(posedge i_clk); #3 i_reset = 1'b1;
      @(posedge i_clk); #3 i_reset = 1'b0;
      at_neg(); chk32("timeout_cleared", 32'(o_timeout), 0);

      // randomized traffic, checked by the per-cycle model compare
      left[0] = 0; left[1] = 0;
      for (int i = 0; i < 3000; i++) begin
         at_neg();
         ak[0] = o_m0_ack; ak[1] = o_m1_ack;
         step();
         if (i_reset) begin
            #2 i_reset = 1'b0;
         end else if ($urandom_range(0, 499) == 0) begin
            #2 i_reset = 1'b1;
         end
         s_ack = 1'($urandom_range(0, 1));
         s_dat = $urandom;
         for (int m = 0; m < 2; m++) begin
            if (m_cyc[m]) begin
               if (ak[m]) begin
                  left[m]--;
                  if (left[m] <= 0) begin
                     m_cyc[m] = 0; m_stb[m] = 0;
                  end else begin
                     m_adr[m] = m_adr[m] + 4;
                     m_dat[m] = $urandom;
                     m_cti[m] = (left[m] == 1) ? 3'b111 : 3'b010;
                  end
               end
            end else if ($urandom_range(0, 3) == 0) begin
               left[m] = $urandom_range(1, 4);
               drive_m(m, 1, 1'($urandom_range(0, 1)), $urandom, $urandom,
                       4'($urandom_range(0, 15)), (left[m] == 1) ? 3'b000 : 3'b010);
            end
         end
      end
      at_neg();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/zap_wb_arbiter.md
# zap_wb_arbiter

Two-master to one-slave Wishbone arbiter that shares a single RAM or memory port between the ZAP core's data bus (master 0) and a second requester (master 1), such as a loader, DMA or debug port. Grant is registered and decided by round-robin. A grant is held for the whole Wishbone cycle (CYC high), so CTI bursts are never split. The block sits between the bus masters and one slave port, for example the primary port of `model_ram_dual`.

## Interface
- TIMEOUT_CYCLES, 1024: cycles of unacknowledged slave STB before a synthetic ack is issued (only used with ZAP_WB_ARB_TIMEOUT_EN).
- i_clk  in  1  system clock; all state on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_m0_cyc, i_m0_stb, i_m0_we  in  1 each  master 0 (core data bus) cycle/strobe/write.
- i_m0_adr  in  32  master 0 address.
- i_m0_dat  in  32  master 0 write data.
- i_m0_sel  in  4  master 0 byte select.
- i_m0_cti  in  3  master 0 cycle type.
- o_m0_dat  out  32  master 0 read data.
- o_m0_ack  out  1  master 0 acknowledge.
- i_m1_* / o_m1_*: same set and widths for master 1.
- o_s_cyc, o_s_stb, o_s_we  out  1 each  slave cycle/strobe/write.
- o_s_adr  out  32  slave address.
- o_s_dat  out  32  slave write data.
- o_s_sel  out  4  slave byte select.
- o_s_cti  out  3  slave cycle type.
- i_s_dat  in  32  slave read data.
- i_s_ack  in  1  slave acknowledge.
- o_gnt  out  2  one-hot current grant; 2'b00 when idle.
- o_timeout  out  1  sticky timeout flag.

## Operation
- State machine has three states: IDLE, GNT0, GNT1.
- One internal register, `last`, records the master granted most recently. Reset value is 1, so master 0 wins the first tie.
- From IDLE:
  - only m0_cyc high → GNT0.
  - only m1_cyc high → GNT1.
  - both high → grant the master that is not `last`.
  - neither high → stay in IDLE.
- On entering GNTx, `last` is set to x.
- In GNTx, stay while i_mx_cyc is high. When i_mx_cyc is low → IDLE.
- No direct handover between masters; IDLE always sits between two grants.
- Slave outputs are combinationally muxed from the granted master. In IDLE, all slave outputs are 0.
- o_s_cyc and o_s_stb are gated with the grant: o_s_cyc = i_mx_cyc while in GNTx.
- o_mx_ack = i_s_ack when granted to x, else 0.
- o_mx_dat = i_s_dat when granted to x, else 32'h0.
- An ungranted master sees no ack and simply waits with CYC/STB held. No request is ever dropped.
- CTI is passed through unchanged. The arbiter does not interpret bursts beyond holding the grant while CYC is high.

## Timing
- Grant latency: master raises CYC in cycle N with the arbiter in IDLE → o_gnt and o_s_cyc assert in N+1.
- Release: master drops CYC in cycle M → IDLE at M+1. The earliest next grant is visible at M+2.
- Ack/data path is combinational, with zero added latency after grant.
- Reset:
  - on assertion, immediately (asynchronously) forces state IDLE, `last`=1, o_timeout=0 and the timeout counter to 0.
  - all outputs go to 0 in the same cycle, including mid-transfer. An in-flight transfer is abandoned.
- Simultaneous events:
  - a new request from the other master in the cycle the current master drops CYC is decided in IDLE at the next edge.
  - if the dropping master re-requests in IDLE together with the other master, the round-robin rule gives the grant to the other master.
- If a master drops CYC while i_s_ack is high, that ack is still forwarded in that cycle, then the arbiter goes to IDLE.

## Configuration
- Macro: ZAP_WB_ARB_TIMEOUT_EN.
- Defined:
  - a counter of width $clog2(TIMEOUT_CYCLES)+1 increments each cycle o_s_stb=1 and i_s_ack=0.
  - the counter clears on i_s_ack, or when leaving GNTx.
  - when the counter reaches TIMEOUT_CYCLES, the granted master receives a one-cycle synthetic o_mx_ack with o_mx_dat=32'hDEAD_BEEF, and o_s_stb is forced to 0 in that cycle.
  - in the same cycle o_timeout is set; it stays set until reset. The counter then clears.
- Undefined: no counter, o_timeout tied 0, TIMEOUT_CYCLES ignored.

## Test plan
- Reset: assert i_reset mid-simulation with both masters active → every output reads 0 in the same cycle; o_gnt=2'b00.
- Single request: m0 reads adr 32'h7C8, slave acks with 32'h1234_5678 one cycle after STB → o_gnt=2'b01 one cycle after CYC; o_m0_dat=32'h1234_5678 with o_m0_ack; o_m1_ack stays 0.
- Round-robin: both masters continuously issue single-beat cycles (drop CYC after each ack) → grants observed 01,10,01,10, with m0 first after reset and one IDLE cycle between grants.
- Burst hold: m1 issues a 4-beat CTI=3'b010/3'b111 burst; m0 raises CYC after beat 1 → all 4 beats go to m1 uninterrupted; m0 is granted 2 cycles after m1 drops CYC.
- Write mux: m1 writes 32'hCAFE_F00D, sel 4'b0011, to 32'h800 while m0 waits → o_s_dat, o_s_sel, o_s_we and o_s_adr match m1 exactly; no m0 values leak.
- Timeout (ZAP_WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): slave never acks m0 → synthetic o_m0_ack with 32'hDEAD_BEEF after 8 stalled cycles; o_timeout=1 until reset. Without the macro, m0 stalls indefinitely and o_timeout=0.
